core_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the core's single 16-bit transmit channel between two result producers: the FFT result bank (burst of up to 255 words) and the FIR output (typically one word). It sits between the compute engines and the UART-side transmitter. Each grant moves one complete burst out word by word over the data_out_valid / tx_done handshake, then signals completion to the granted requester.

---
 rtl/core_tx_arbiter_if.sv | 43 ++++
 rtl/core_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_core_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_tx_arbiter_if.sv
// Transmit-channel bundle between two burst requesters, the arbiter and the UART-side transmitter.
interface core_tx_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
);

    // Requester side
    logic              req0;
    logic              req1;
    logic [LEN_W-1:0]  len0;
    logic [LEN_W-1:0]  len1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic [LEN_W-1:0]  rd_addr0;
    logic [LEN_W-1:0]  rd_addr1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;

    // Transmitter side
    logic              tx_done;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;

    // Status
    logic              busy;

    // Arbiter view
    modport master (
        input  req0, req1, len0, len1, rd_data0, rd_data1, tx_done,
        output rd_addr0, rd_addr1, gnt0, gnt1, done0, done1,
               data_out, data_out_valid, busy
    );

    // Requester / transmitter / environment view
    modport slave (
        output req0, req1, len0, len1, rd_data0, rd_data1, tx_done,
        input  rd_addr0, rd_addr1, gnt0, gnt1, done0, done1,
               data_out, data_out_valid, busy
    );

endinterface

// File: rtl/core_tx_arbiter.sv
// Round-robin scheduler sharing one transmit channel between the FFT bank (ch0) and FIR output (ch1).
// Each grant streams a whole burst word by word over data_out_valid / tx_done, then pulses done.
module core_tx_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic clk,
    input  logic rstb,
    core_tx_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [LEN_W-1:0]  rd_addr0_q, rd_addr0_d;
    logic [LEN_W-1:0]  rd_addr1_q, rd_addr1_d;
    logic              busy_q, busy_d;
    logic              tx_done_q;
    logic              ack;

    // Word acknowledge is the rising edge of tx_done; a level already high on WAIT entry is not an ack
    assign ack = bus.tx_done & ~tx_done_q;

    // State and output registers; reset drops everything at once and returns priority to ch0
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rd_addr0_q <= rd_addr0_d;
            rd_addr1_q <= rd_addr1_d;
            busy_q     <= busy_d;
            tx_done_q  <= bus.tx_done;
        end
    end

    // Next-state and next-output logic for the IDLE/LOAD/WAIT/DONE burst sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        sel_d   = sel_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = 1'b0;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // With both pending, serve whichever channel was not served last
                    if (bus.req0 && bus.req1) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = bus.req1;
                    end
                    len_d   = sel_d ? bus.len1 : bus.len0;
                    addr_d  = '0;
                    gnt0_d  = ~sel_d;
                    gnt1_d  = sel_d;
                    state_d = (len_d == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = sel_q ? bus.rd_data1 : bus.rd_data0;
                valid_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ack) begin
                    if (addr_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + LEN_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done0_d = ~sel_q;
                done1_d = sel_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = sel_q;
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Each read address tracks the burst index only while its channel holds the grant
        rd_addr0_d = gnt0_d ? addr_d : '0;
        rd_addr1_d = gnt1_d ? addr_d : '0;

        // Busy covers every non-idle cycle plus the cycle carrying the done pulse
        busy_d = (state_d != S_IDLE) || done0_d || done1_d;
    end

    assign bus.data_out       = data_q;
    assign bus.data_out_valid = valid_q;
    assign bus.gnt0           = gnt0_q;
    assign bus.gnt1           = gnt1_q;
    assign bus.done0          = done0_q;
    assign bus.done1          = done1_q;
    assign bus.rd_addr0       = rd_addr0_q;
    assign bus.rd_addr1       = rd_addr1_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_core_tx_arbiter.sv
// Scoreboard bench for core_tx_arbiter: stimulus pushes expected words/dones, a monitor pops and compares.
module tb_core_tx_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 8;

    typedef struct packed {
        logic        ch;
        logic [15:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rstb;

    core_tx_arbiter_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    core_tx_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Requester buffers: word = base + mul * address
    logic [15:0] base0, mul0, base1, mul1;
    assign bus.rd_data0 = 16'(base0 + mul0 * 16'(bus.rd_addr0));
    assign bus.rd_data1 = 16'(base1 + mul1 * 16'(bus.rd_addr1));

    word_t exp_q[$];
    logic  exp_done_q[$];
    int    tests;
    int    errors;
    int    valid_count;
    int    done_count;
    int    hold_reqs;
    bit    auto_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic ch, input int len, input logic [15:0] base, input logic [15:0] mul);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{ch: ch, data: 16'(base + mul * 16'(i))});
        end
    endtask

    // Monitor: compares every presented word and done pulse against the scoreboard
    task automatic monitor();
        word_t w;
        logic  dch;
        forever begin
            @(negedge clk);
            if (rstb) begin
                check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                if (bus.data_out_valid) begin
                    valid_count++;
                    check("valid_under_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd1);
                    if (exp_q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none", bus.data_out);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_channel", 32'(bus.gnt1), 32'(w.ch));
                        check("word_data", 32'(bus.data_out), 32'(w.data));
                    end
                end
                if (bus.done0 || bus.done1) begin
                    done_count++;
                    if (exp_done_q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_done: got ch%0d expected none", bus.done1);
                    end else begin
                        dch = exp_done_q.pop_front();
                        check("done_channel", {30'd0, bus.done1, bus.done0}, dch ? 32'd2 : 32'd1);
                    end
                    // Requesters release req on their done, unless told to keep both up for N bursts
                    if (hold_reqs > 0) begin
                        hold_reqs--;
                        if (hold_reqs == 0) begin
                            bus.req0 = 1'b0;
                            bus.req1 = 1'b0;
                        end
                    end else begin
                        if (bus.done0) bus.req0 = 1'b0;
                        if (bus.done1) bus.req1 = 1'b0;
                    end
                end
            end
        end
    endtask

    // Transmitter model: one cycle after a valid word, pulse tx_done for one cycle
    task automatic transmitter();
        forever begin
            @(negedge clk);
            if (auto_tx && bus.data_out_valid) begin
                @(negedge clk);
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_count >= target), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        int dc;
        rstb         = 1'b0;
        bus.req0     = 1'b0;
        bus.req1     = 1'b0;
        bus.len0     = '0;
        bus.len1     = '0;
        bus.tx_done  = 1'b0;
        base0 = '0; mul0 = '0; base1 = '0; mul1 = '0;
        tests = 0; errors = 0; valid_count = 0; done_count = 0;
        hold_reqs = 0; auto_tx = 1'b0;

        fork
            monitor();
            transmitter();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_valid", 32'(bus.data_out_valid), 32'd0);
        check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        check("rst_rd_addr", {16'd0, bus.rd_addr1, bus.rd_addr0}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single word on ch1
        base1 = 16'h1234; mul1 = 16'd0; bus.len1 = 8'd1;
        push_burst(1'b1, 1, 16'h1234, 16'd0);
        exp_done_q.push_back(1'b1);
        bus.req1 = 1'b1;
        @(negedge clk);
        check("single_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        check("single_busy", 32'(bus.busy), 32'd1);
        check("single_no_valid_yet", 32'(bus.data_out_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(bus.data_out_valid), 32'd1);
        check("single_data", 32'(bus.data_out), 32'h1234);
        bus.tx_done = 1'b1;
        @(negedge clk);
        check("single_gnt_hold", 32'(bus.gnt1), 32'd1);
        check("single_no_done_yet", 32'(bus.done1), 32'd0);
        bus.tx_done = 1'b0;
        @(negedge clk);
        check("single_done1", 32'(bus.done1), 32'd1);
        check("single_gnt_drop", 32'(bus.gnt1), 32'd0);
        check("single_busy_tail", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("single_busy_fall", 32'(bus.busy), 32'd0);
        check("single_done_pulse", 32'(bus.done1), 32'd0);
        check("single_data_hold", 32'(bus.data_out), 32'h1234);

        // Full 128-word burst on ch0
        base0 = 16'd0; mul0 = 16'd3; bus.len0 = 8'd128;
        push_burst(1'b0, 128, 16'd0, 16'd3);
        exp_done_q.push_back(1'b0);
        vc = valid_count;
        dc = done_count;
        auto_tx = 1'b1;
        bus.req0 = 1'b1;
        wait_done(dc + 1, 1000, "burst_done_seen");
        repeat (2) @(negedge clk);
        auto_tx = 1'b0;
        check("burst_word_count", 32'(valid_count - vc), 32'd128);
        check("burst_queue_empty", 32'(exp_q.size()), 32'd0);
        check("burst_last_data", 32'(bus.data_out), 32'd381);

        // Zero-length burst on ch0
        bus.len0 = 8'd0;
        exp_done_q.push_back(1'b0);
        vc = valid_count;
        check("zero_busy_before", 32'(bus.busy), 32'd0);
        bus.req0 = 1'b1;
        @(negedge clk);
        check("zero_gnt0", 32'(bus.gnt0), 32'd1);
        check("zero_busy1", 32'(bus.busy), 32'd1);
        check("zero_no_done_yet", 32'(bus.done0), 32'd0);
        @(negedge clk);
        check("zero_done0", 32'(bus.done0), 32'd1);
        check("zero_gnt_drop", 32'(bus.gnt0), 32'd0);
        check("zero_busy2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("zero_busy_fall", 32'(bus.busy), 32'd0);
        check("zero_no_words", 32'(valid_count - vc), 32'd0);

        // Contention from reset: both held for four bursts, expect ch0, ch1, ch0, ch1
        rstb = 1'b0;
        base0 = 16'h0A00; mul0 = 16'd1; base1 = 16'h0B00; mul1 = 16'd1;
        bus.len0 = 8'd2; bus.len1 = 8'd2;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        hold_reqs = 4;
        for (int b = 0; b < 4; b++) begin
            push_burst(1'(b % 2), 2, (b % 2 == 0) ? 16'h0A00 : 16'h0B00, 16'd1);
            exp_done_q.push_back(1'(b % 2));
        end
        dc = done_count;
        auto_tx = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("contend_first_ch0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        wait_done(dc + 4, 200, "contend_done_seen");
        repeat (4) @(negedge clk);
        auto_tx = 1'b0;
        check("contend_idle", 32'(bus.busy), 32'd0);
        check("contend_words_empty", 32'(exp_q.size()), 32'd0);
        check("contend_dones_empty", 32'(exp_done_q.size()), 32'd0);

        // Handshake edges: pulses in IDLE/LOAD ignored, held-high tx_done advances one word only
        base1 = 16'h0100; mul1 = 16'd1; bus.len1 = 8'd3;
        vc = valid_count;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        @(negedge clk);
        check("idle_pulse_busy", 32'(bus.busy), 32'd0);
        check("idle_pulse_words", 32'(valid_count - vc), 32'd0);
        push_burst(1'b1, 3, 16'h0100, 16'd1);
        exp_done_q.push_back(1'b1);
        dc = done_count;
        bus.req1 = 1'b1;
        @(negedge clk);
        check("hs_gnt1", 32'(bus.gnt1), 32'd1);
        bus.tx_done = 1'b1;
        repeat (6) @(negedge clk);
        check("load_pulse_ignored", 32'(valid_count - vc), 32'd1);
        check("load_pulse_gnt", 32'(bus.gnt1), 32'd1);
        bus.tx_done = 1'b0;
        @(negedge clk);
        bus.tx_done = 1'b1;
        repeat (8) @(negedge clk);
        check("held_one_word", 32'(valid_count - vc), 32'd2);
        check("held_rd_addr1", 32'(bus.rd_addr1), 32'd1);
        bus.tx_done = 1'b0;
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("third_word", 32'(valid_count - vc), 32'd3);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        wait_done(dc + 1, 20, "hs_done_seen");
        repeat (2) @(negedge clk);
        check("hs_idle", 32'(bus.busy), 32'd0);

        // Reset during word 5 of a 10-word ch0 burst
        base0 = 16'h0050; mul0 = 16'd2; bus.len0 = 8'd10;
        push_burst(1'b0, 10, 16'h0050, 16'd2);
        vc = valid_count;
        dc = done_count;
        auto_tx = 1'b1;
        bus.req0 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (valid_count - vc >= 5) break;
        end
        check("reach_word5", 32'(valid_count - vc), 32'd5);
        rstb = 1'b0;
        auto_tx = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
        check("mid_rst_valid", 32'(bus.data_out_valid), 32'd0);
        check("mid_rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("mid_rst_rd_addr0", 32'(bus.rd_addr0), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        repeat (3) @(negedge clk);
        bus.tx_done = 1'b0;
        exp_q.delete();
        check("no_done_on_reset", 32'(done_count - dc), 32'd0);
        rstb = 1'b1;
        @(negedge clk);
        check("post_rst_quiet", 32'(done_count - dc), 32'd0);
        base0 = 16'h0011; mul0 = 16'd0; base1 = 16'h0022; mul1 = 16'd0;
        bus.len0 = 8'd1; bus.len1 = 8'd1;
        push_burst(1'b0, 1, 16'h0011, 16'd0);
        push_burst(1'b1, 1, 16'h0022, 16'd0);
        exp_done_q.push_back(1'b0);
        exp_done_q.push_back(1'b1);
        auto_tx = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        check("prio_after_reset", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        wait_done(dc + 2, 100, "post_rst_dones");
        repeat (4) @(negedge clk);
        auto_tx = 1'b0;
        check("final_words_empty", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
